// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS load path: access-size codes, buffer states
// and the alignment rule used by every lane extractor.
package mips_pkg;

  localparam int WORD_DEF = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  // A half must sit on an even byte and a word on offset 0; the reserved
  // size is always rejected.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic       ofs_lsb,
                                         input logic       ofs_nz);
    return (size == SZ_HALF && ofs_lsb) ||
           (size == SZ_WORD && ofs_nz)  ||
           (size == SZ_RSVD);
  endfunction

endpackage

// File: rtl/lane_ext.sv
// Combinational little-endian lane select plus sign/zero extension.
// Also serves the immediate path (half, offset 0).
module lane_ext
  import mips_pkg::*;
#(
  parameter  int WORD  = WORD_DEF,
  localparam int OFS_W = $clog2(WORD / 8)
) (
  input  logic [WORD-1:0]  i_data,
  input  logic [OFS_W-1:0] i_ofs,
  input  logic [1:0]       i_size,
  input  logic             i_unsigned,
  output logic [WORD-1:0]  o_ext,
  output logic             o_misalign
);

  logic [OFS_W-1:0] w_hidx;
  logic [WORD-1:0]  w_byte_sh;
  logic [WORD-1:0]  w_half_sh;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic             w_mis;

  assign w_hidx    = i_ofs >> 1;
  assign w_byte_sh = i_data >> {i_ofs, 3'b000};
  assign w_half_sh = i_data >> {w_hidx, 4'b0000};
  assign w_byte    = w_byte_sh[7:0];
  assign w_half    = w_half_sh[15:0];
  assign w_mis     = is_misaligned(i_size, i_ofs[0], |i_ofs);

  // Misaligned or reserved accesses produce a zero result.
  always_comb begin
    o_ext = '0;
    if (!w_mis) begin
      case (i_size)
        SZ_BYTE: o_ext = i_unsigned ? WORD'(w_byte) : WORD'($signed(w_byte));
        SZ_HALF: o_ext = i_unsigned ? WORD'(w_half) : WORD'($signed(w_half));
        SZ_WORD: o_ext = i_data;
        default: o_ext = '0;
      endcase
    end
  end

  assign o_misalign = w_mis;

endmodule

// File: rtl/load_ext_pipe.sv
// MEM/WB load extraction stage: lane select/extend on input, registered
// output behind a valid/ready handshake with a 2-entry skid buffer.
module load_ext_pipe
  import mips_pkg::*;
#(
  parameter  int WORD  = WORD_DEF,
  parameter  int TAG_W = 5,
  localparam int OFS_W = $clog2(WORD / 8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WORD-1:0]  in_data,
  input  logic [OFS_W-1:0] in_ofs,
  input  logic [1:0]       in_size,
  input  logic             in_unsigned,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WORD-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_misalign
);

  buf_state_e       r_state;
  buf_state_e       w_state_next;
  logic             r_in_ready;
  logic [WORD-1:0]  r_out_data;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_mis;
  logic [WORD-1:0]  r_skd_data;
  logic [TAG_W-1:0] r_skd_tag;
  logic             r_skd_mis;

  logic [WORD-1:0]  w_ext;
  logic             w_mis;
  logic             w_acc;
  logic             w_xfer;
  logic             w_ld_out;
  logic             w_ld_skd;
  logic             w_skd_to_out;

  lane_ext #(.WORD(WORD)) u_lane_ext (
    .i_data     (in_data),
    .i_ofs      (in_ofs),
    .i_size     (in_size),
    .i_unsigned (in_unsigned),
    .o_ext      (w_ext),
    .o_misalign (w_mis)
  );

  // Masked by rst so nothing is accepted while reset is asserted.
  assign in_ready  = r_in_ready & ~rst;
  assign out_valid = (r_state != EMPTY);
  assign w_acc     = in_valid & in_ready;
  assign w_xfer    = out_valid & out_ready;

  always_comb begin
    w_state_next = r_state;
    w_ld_out     = 1'b0;
    w_ld_skd     = 1'b0;
    w_skd_to_out = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_acc) begin
          w_ld_out     = 1'b1;
          w_state_next = ONE;
        end
      end
      ONE: begin
        if (w_acc && w_xfer) begin
          w_ld_out = 1'b1;
        end else if (w_acc) begin
          w_ld_skd     = 1'b1;
          w_state_next = FULL;
        end else if (w_xfer) begin
          w_state_next = EMPTY;
        end
      end
      FULL: begin
        if (w_xfer) begin
          w_skd_to_out = 1'b1;
          w_state_next = ONE;
        end
      end
      default: w_state_next = EMPTY;
    endcase
    // Flush drops everything; a transfer in this cycle has already happened.
    if (flush) begin
      w_state_next = EMPTY;
      w_ld_out     = 1'b0;
      w_ld_skd     = 1'b0;
      w_skd_to_out = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      r_out_data <= '0;
      r_out_tag  <= '0;
      r_out_mis  <= 1'b0;
      r_skd_data <= '0;
      r_skd_tag  <= '0;
      r_skd_mis  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != FULL);
      if (w_ld_out) begin
        r_out_data <= w_ext;
        r_out_tag  <= in_tag;
        r_out_mis  <= w_mis;
      end else if (w_skd_to_out) begin
        r_out_data <= r_skd_data;
        r_out_tag  <= r_skd_tag;
        r_out_mis  <= r_skd_mis;
      end
      if (w_ld_skd) begin
        r_skd_data <= w_ext;
        r_skd_tag  <= in_tag;
        r_skd_mis  <= w_mis;
      end
    end
  end

  assign out_data     = r_out_data;
  assign out_tag      = r_out_tag;
  assign out_misalign = r_out_mis;

endmodule

// File: tb/tb_load_ext_pipe.sv
// Bench for load_ext_pipe: directed vector table, handshake corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_load_ext_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_unsigned;
  logic [31:0] in_data;
  logic [1:0]  in_ofs, in_size;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready, out_misalign;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  always #5 clk = ~clk;

  load_ext_pipe #(.WORD(32), .TAG_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_ofs       (in_ofs),
    .in_size      (in_size),
    .in_unsigned  (in_unsigned),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_tag      (out_tag),
    .out_misalign (out_misalign)
  );

  typedef struct {
    logic [31:0] d;
    logic [4:0]  t;
    logic        m;
  } ent_t;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  o;
    logic [1:0]  s;
    logic        u;
    logic [31:0] exp_d;
    logic        exp_m;
  } vec_t;

  ent_t q[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Reference: lane value by division/modulo, sign-extend by adding 2^32 - 2^bits.
  function automatic logic [32:0] ref_ext(input logic [31:0] d, input int o, input int s, input bit u);
    longint unsigned v;
    int shift, bits;
    bit mis;
    bits = 0; shift = 0; mis = 1'b1;
    case (s)
      0: begin bits = 8;  shift = 8 * o;        mis = 1'b0;      end
      1: begin bits = 16; shift = 16 * (o / 2); mis = (o % 2) != 0; end
      2: begin bits = 32; shift = 0;            mis = (o != 0);  end
      default: mis = 1'b1;
    endcase
    if (mis) return {1'b1, 32'h0};
    v = longint'(d);
    v = (v / (64'd1 << shift)) % (64'd1 << bits);
    if (!u && bits < 32 && v >= (64'd1 << (bits - 1)))
      v = v + (64'd1 << 32) - (64'd1 << bits);
    return {1'b0, v[31:0]};
  endfunction

  // One clock: drive inputs, advance the model at the edge, check 1 ns later.
  task automatic step(input logic v, input logic [31:0] d, input logic [1:0] o,
                      input logic [1:0] s, input logic u, input logic [4:0] t,
                      input logic ordy, input logic fl, input logic r);
    bit acc, xfr;
    logic [32:0] res;
    ent_t e;
    in_valid = v; in_data = d; in_ofs = o; in_size = s; in_unsigned = u;
    in_tag = t; out_ready = ordy; flush = fl; rst = r;
    acc = v && !r && (q.size() < 2);
    xfr = ordy && (q.size() > 0);
    res = ref_ext(d, int'(o), int'(s), u);
    e.d = res[31:0]; e.m = res[32]; e.t = t;
    @(posedge clk);
    if (r) q.delete();
    else begin
      if (xfr) begin
        $display("xfer tag=%0d data=%h mis=%0d", q[0].t, q[0].d, q[0].m);
        void'(q.pop_front());
      end
      if (fl) q.delete();
      else if (acc) q.push_back(e);
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, !r && (q.size() < 2)});
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_tag", {27'd0, out_tag}, {27'd0, q[0].t});
      chk("out_misalign", {31'd0, out_misalign}, {31'd0, q[0].m});
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 5'd0, ordy, 1'b0, 1'b0);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{32'h80FF7F01, 2'd1, 2'd0, 1'b0, 32'h0000007F, 1'b0};
    vecs[1]  = '{32'h80FF7F01, 2'd2, 2'd0, 1'b0, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{32'h80FF7F01, 2'd3, 2'd0, 1'b1, 32'h00000080, 1'b0};
    vecs[3]  = '{32'h80FF7F01, 2'd0, 2'd0, 1'b0, 32'h00000001, 1'b0};
    vecs[4]  = '{32'h8001C0DE, 2'd2, 2'd1, 1'b0, 32'hFFFF8001, 1'b0};
    vecs[5]  = '{32'h8001C0DE, 2'd0, 2'd1, 1'b1, 32'h0000C0DE, 1'b0};
    vecs[6]  = '{32'h8001C0DE, 2'd0, 2'd1, 1'b0, 32'hFFFFC0DE, 1'b0};
    vecs[7]  = '{32'h8001C0DE, 2'd1, 2'd1, 1'b0, 32'h00000000, 1'b1};
    vecs[8]  = '{32'h8001C0DE, 2'd0, 2'd3, 1'b0, 32'h00000000, 1'b1};
    vecs[9]  = '{32'h8001C0DE, 2'd0, 2'd2, 1'b1, 32'h8001C0DE, 1'b0};
    vecs[10] = '{32'h8001C0DE, 2'd2, 2'd2, 1'b0, 32'h00000000, 1'b1};
    vecs[11] = '{32'h8001C0DE, 2'd3, 2'd0, 1'b0, 32'hFFFFFF80, 1'b0};

    // Reset state
    step(1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_tag", {27'd0, out_tag}, 32'h0);
    idle(1'b0);

    // Directed vectors, one per cycle with the consumer always ready
    for (int i = 0; i < 12; i++) begin
      step(1'b1, vecs[i].d, vecs[i].o, vecs[i].s, vecs[i].u, 5'(i + 1), 1'b1, 1'b0, 1'b0);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_d);
      chk($sformatf("vec%0d_mis", i), {31'd0, out_misalign}, {31'd0, vecs[i].exp_m});
      chk($sformatf("vec%0d_tag", i), {27'd0, out_tag}, 32'(i + 1));
    end
    idle(1'b1);

    // Backpressure: tags 1,2 fill OUT/SKD, tag 3 waits, then drain in order
    step(1'b1, 32'h11111111, 2'd0, 2'd2, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h22222222, 2'd0, 2'd2, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    step(1'b1, 32'h33333333, 2'd0, 2'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
    chk("bp_hold_tag", {27'd0, out_tag}, 32'd1);
    chk("bp_hold_data", out_data, 32'h11111111);
    step(1'b1, 32'h33333333, 2'd0, 2'd2, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("bp_tag2", {27'd0, out_tag}, 32'd2);
    step(1'b1, 32'h33333333, 2'd0, 2'd2, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("bp_tag3", {27'd0, out_tag}, 32'd3);
    idle(1'b1);
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Full throughput
    for (int i = 0; i < 8; i++) begin
      step(1'b1, $urandom, 2'd0, 2'd2, 1'b0, 5'(10 + i), 1'b1, 1'b0, 1'b0);
      chk("tp_tag", {27'd0, out_tag}, 32'(10 + i));
      chk("tp_in_ready", {31'd0, in_ready}, 32'd1);
    end
    idle(1'b1);

    // Flush while FULL with a new input offered
    step(1'b1, 32'hAAAA0001, 2'd0, 2'd2, 1'b0, 5'd20, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hAAAA0002, 2'd0, 2'd2, 1'b0, 5'd21, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hAAAA0003, 2'd0, 2'd2, 1'b0, 5'd22, 1'b0, 1'b1, 1'b0);
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    idle(1'b1);
    idle(1'b1);
    chk("fl_nothing_left", {31'd0, out_valid}, 32'd0);

    // Reset while FULL, then 1-cycle latency afterwards
    step(1'b1, 32'h12345678, 2'd0, 2'd2, 1'b0, 5'd30, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h9ABCDEF0, 2'd0, 2'd2, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h55555555, 2'd0, 2'd2, 1'b0, 5'd29, 1'b0, 1'b0, 1'b1);
    chk("mr_out_data", out_data, 32'h0);
    chk("mr_out_tag", {27'd0, out_tag}, 32'h0);
    chk("mr_out_mis", {31'd0, out_misalign}, 32'h0);
    step(1'b1, 32'h0000BEEF, 2'd0, 2'd1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    chk("mr_after_tag", {27'd0, out_tag}, 32'd9);
    chk("mr_after_data", out_data, 32'h0000BEEF);
    idle(1'b1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 2'($urandom), 2'($urandom),
           1'($urandom), 5'($urandom), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 79) == 0));
    end
    for (int i = 0; i < 3; i++) idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
